// File: rtl/prime_search_control_pkg.sv
// -----------------------------------------------------------------------------
// prime_search_control_pkg
// Shared definitions for the prime search control block:
//   - 3-bit FSM state encodings (legacy-compatible localparams)
//   - FIRST_DIVISOR : first trial divisor of every search (2)
//   - is_busy_state : helper classifying states that belong to an active search
// -----------------------------------------------------------------------------
package prime_search_control_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CHECK    = 3'd1;
   localparam logic [2:0] ST_DIV_REQ  = 3'd2;
   localparam logic [2:0] ST_DIV_RESP = 3'd3;
   localparam logic [2:0] ST_INCR     = 3'd4;
   localparam logic [2:0] ST_DONE     = 3'd5;

   localparam int unsigned FIRST_DIVISOR = 2;

   // A search is in progress in every state except IDLE and DONE.
   function automatic logic is_busy_state(input logic [2:0] state);
      return (state != ST_IDLE) && (state != ST_DONE);
   endfunction

endpackage

// File: rtl/prime_divisor_gen.sv
// -----------------------------------------------------------------------------
// prime_divisor_gen
// Trial-divisor register with its step logic and the early-termination compare.
//   clk, reset       : clock, asynchronous active-high reset (divisor -> 0)
//   i_load           : start of a new search, divisor <= FIRST_DIVISOR
//   i_step           : advance divisor (2 -> 3, then +1 or +2)
//   i_odd_only       : step by 2 after the first odd divisor
//   i_value          : value under test
//   o_divisor        : current divisor
//   o_sq_gt_value    : divisor*divisor > value (full 2*nbits product)
// -----------------------------------------------------------------------------
module prime_divisor_gen
   import prime_search_control_pkg::*;
#(
   parameter int unsigned nbits = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_odd_only,
   input  logic [nbits-1:0] i_value,
   output logic [nbits-1:0] o_divisor,
   output logic             o_sq_gt_value
);

   logic [nbits-1:0]   r_divisor;
   logic [nbits-1:0]   w_next_divisor;
   logic [2*nbits-1:0] w_div_wide;
   logic [2*nbits-1:0] w_value_wide;
   logic [2*nbits-1:0] w_square;

   always_comb begin
      w_next_divisor = r_divisor + nbits'(1);
      if (r_divisor == nbits'(FIRST_DIVISOR)) begin
         w_next_divisor = nbits'(FIRST_DIVISOR + 1);
      end else if (i_odd_only) begin
         w_next_divisor = r_divisor + nbits'(2);
      end
   end

   // Square is formed at double width so the compare never overflows.
   assign w_div_wide    = {{nbits{1'b0}}, r_divisor};
   assign w_value_wide  = {{nbits{1'b0}}, i_value};
   assign w_square      = w_div_wide * w_div_wide;
   assign o_sq_gt_value = (w_square > w_value_wide);
   assign o_divisor     = r_divisor;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_divisor <= '0;
      end else if (i_load) begin
         r_divisor <= nbits'(FIRST_DIVISOR);
      end else if (i_step) begin
         r_divisor <= w_next_divisor;
      end
   end

endmodule

// File: rtl/prime_search_control.sv
// -----------------------------------------------------------------------------
// prime_search_control
// Trial-division prime search controller driving an external divider over
// val/rdy streams. Terminates once divisor^2 > value; optional odd-only step.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   req_val/req_rdy/req_value/req_odd_only : request interface
//   div_istream_val/rdy, div_dividend, div_divisor : divider operand stream
//   div_ostream_val/rdy, div_remainder             : divider result stream
//   busy, done, is_prime, factor  : status and result (held in DONE)
//   cycles (PRIME_CTRL_CYCLE_COUNT_EN only) : clk edges from accept to done
// Configuration macro: PRIME_CTRL_CYCLE_COUNT_EN
// -----------------------------------------------------------------------------
module prime_search_control
   import prime_search_control_pkg::*;
#(
   parameter int unsigned nbits = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_val,
   output logic             req_rdy,
   input  logic [nbits-1:0] req_value,
   input  logic             req_odd_only,
   output logic             div_istream_val,
   input  logic             div_istream_rdy,
   output logic [nbits-1:0] div_dividend,
   output logic [nbits-1:0] div_divisor,
   input  logic             div_ostream_val,
   output logic             div_ostream_rdy,
   input  logic [nbits-1:0] div_remainder,
   output logic             busy,
`ifdef PRIME_CTRL_CYCLE_COUNT_EN
   output logic [31:0]      cycles,
`endif
   output logic             done,
   output logic             is_prime,
   output logic [nbits-1:0] factor
);

   logic [2:0]       r_state;
   logic [nbits-1:0] r_value;
   logic             r_odd_only;
   logic             r_done;
   logic             r_is_prime;
   logic [nbits-1:0] r_factor;

   logic             w_accept;
   logic             w_step;
   logic [nbits-1:0] w_divisor;
   logic             w_sq_gt_value;

   assign req_rdy         = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_accept        = req_val && req_rdy;
   assign w_step          = (r_state == ST_INCR);
   assign busy            = is_busy_state(r_state);
   assign div_istream_val = (r_state == ST_DIV_REQ);
   assign div_ostream_rdy = (r_state == ST_DIV_RESP);
   assign div_dividend    = r_value;
   assign div_divisor     = w_divisor;
   assign done            = r_done;
   assign is_prime        = r_is_prime;
   assign factor          = r_factor;

   prime_divisor_gen #(
      .nbits (nbits)
   ) u_divisor_gen (
      .clk           (clk),
      .reset         (reset),
      .i_load        (w_accept),
      .i_step        (w_step),
      .i_odd_only    (r_odd_only),
      .i_value       (r_value),
      .o_divisor     (w_divisor),
      .o_sq_gt_value (w_sq_gt_value)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_value    <= '0;
         r_odd_only <= 1'b0;
         r_done     <= 1'b0;
         r_is_prime <= 1'b0;
         r_factor   <= '0;
      end else if (w_accept) begin
         // Accept is legal only in IDLE/DONE; operands latched here stay
         // fixed for the whole search regardless of req_value.
         r_value    <= req_value;
         r_odd_only <= req_odd_only;
         r_done     <= 1'b0;
         r_state    <= ST_CHECK;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state <= ST_IDLE;
            end
            ST_CHECK: begin
               if (r_value < nbits'(2)) begin
                  r_state    <= ST_DONE;
                  r_done     <= 1'b1;
                  r_is_prime <= 1'b0;
                  r_factor   <= '0;
               end else if (w_sq_gt_value) begin
                  r_state    <= ST_DONE;
                  r_done     <= 1'b1;
                  r_is_prime <= 1'b1;
                  r_factor   <= '0;
               end else begin
                  r_state <= ST_DIV_REQ;
               end
            end
            ST_DIV_REQ: begin
               if (div_istream_rdy) begin
                  r_state <= ST_DIV_RESP;
               end
            end
            ST_DIV_RESP: begin
               if (div_ostream_val) begin
                  if (div_remainder == '0) begin
                     r_state    <= ST_DONE;
                     r_done     <= 1'b1;
                     r_is_prime <= 1'b0;
                     r_factor   <= w_divisor;
                  end else begin
                     r_state <= ST_INCR;
                  end
               end
            end
            ST_INCR: begin
               r_state <= ST_CHECK;
            end
            ST_DONE: begin
               r_state <= ST_DONE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef PRIME_CTRL_CYCLE_COUNT_EN
   logic [31:0] r_cycles;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycles <= '0;
      end else if (w_accept) begin
         r_cycles <= '0;
      end else if (busy && (r_cycles != '1)) begin
         r_cycles <= r_cycles + 32'd1;
      end
   end

   assign cycles = r_cycles;
`endif

endmodule

// File: tb/tb_prime_search_control.sv
// -----------------------------------------------------------------------------
// tb_prime_search_control
// Table-driven bench with a scoreboard queue and a behavioural divider that
// can stall operand acceptance and delay its response.
// -----------------------------------------------------------------------------
module tb_prime_search_control;

   logic        clk;
   logic        reset;
   logic        req_val;
   logic        req_rdy;
   logic [15:0] req_value;
   logic        req_odd_only;
   logic        div_istream_val;
   logic        div_istream_rdy;
   logic [15:0] div_dividend;
   logic [15:0] div_divisor;
   logic        div_ostream_val;
   logic        div_ostream_rdy;
   logic [15:0] div_remainder;
   logic        busy;
   logic        done;
   logic        is_prime;
   logic [15:0] factor;
`ifdef PRIME_CTRL_CYCLE_COUNT_EN
   logic [31:0] cycles;
`endif

   prime_search_control #(
      .nbits (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_val         (req_val),
      .req_rdy         (req_rdy),
      .req_value       (req_value),
      .req_odd_only    (req_odd_only),
      .div_istream_val (div_istream_val),
      .div_istream_rdy (div_istream_rdy),
      .div_dividend    (div_dividend),
      .div_divisor     (div_divisor),
      .div_ostream_val (div_ostream_val),
      .div_ostream_rdy (div_ostream_rdy),
      .div_remainder   (div_remainder),
      .busy            (busy),
`ifdef PRIME_CTRL_CYCLE_COUNT_EN
      .cycles          (cycles),
`endif
      .done            (done),
      .is_prime        (is_prime),
      .factor          (factor)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] value;
      logic        odd;
      int unsigned stall;
      int unsigned resp;
      logic        exp_prime;
      logic [15:0] exp_factor;
      int unsigned exp_txn;
   } vec_t;

   vec_t vecs [12];
   vec_t exp_q [$];

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Divider model control and observation
   int unsigned stall;
   int unsigned resp_delay;
   int unsigned txn;
   int unsigned seq_err;
   int unsigned stab_err;
   logic [15:0] exp_div;
   logic [15:0] cur_value;
   logic        cur_odd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Behavioural divider: stalls operand acceptance `stall` cycles, answers
   // after `resp_delay` cycles, and checks divisor sequence and stability.
   initial begin : divider_model
      int unsigned d_phase;
      int unsigned d_cnt;
      logic [15:0] d_dd;
      logic [15:0] d_dv;
      logic [15:0] d_rem;
      div_istream_rdy = 1'b0;
      div_ostream_val = 1'b0;
      div_remainder   = '0;
      d_phase = 0;
      d_cnt   = 0;
      d_dd    = '0;
      d_dv    = '0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            div_istream_rdy = 1'b0;
            div_ostream_val = 1'b0;
            d_phase = 0;
            d_cnt   = 0;
         end else begin
            case (d_phase)
               0: begin
                  if (div_istream_val) begin
                     if (d_cnt == 0) begin
                        d_dd = div_dividend;
                        d_dv = div_divisor;
                        if ((d_dv !== exp_div) || (d_dd !== cur_value)) seq_err++;
                     end else if ((div_dividend !== d_dd) || (div_divisor !== d_dv)) begin
                        stab_err++;
                     end
                     if (d_cnt >= stall) begin
                        div_istream_rdy = 1'b1;
                        d_phase = 1;
                     end
                     d_cnt++;
                  end
               end
               1: begin
                  div_istream_rdy = 1'b0;
                  txn++;
                  exp_div = (exp_div == 16'd2) ? 16'd3 : exp_div + (cur_odd ? 16'd2 : 16'd1);
                  d_rem = (d_dv != 0) ? (d_dd % d_dv) : 16'd0;
                  d_cnt = 0;
                  if (resp_delay == 0) begin
                     div_remainder   = d_rem;
                     div_ostream_val = 1'b1;
                     d_phase = 3;
                  end else begin
                     d_phase = 2;
                  end
               end
               2: begin
                  d_cnt++;
                  if (d_cnt >= resp_delay) begin
                     div_remainder   = d_rem;
                     div_ostream_val = 1'b1;
                     d_phase = 3;
                  end
               end
               default: begin
                  div_ostream_val = 1'b0;
                  d_cnt   = 0;
                  d_phase = 0;
               end
            endcase
         end
      end
   end

   // Issue one request, then wait (bounded) for done and score the result.
   task automatic run_vec(input vec_t v);
      vec_t        e;
      int unsigned cyc;
      exp_q.push_back(v);
      @(negedge clk);
      stall      = v.stall;
      resp_delay = v.resp;
      txn        = 0;
      seq_err    = 0;
      stab_err   = 0;
      exp_div    = 16'd2;
      cur_value  = v.value;
      cur_odd    = v.odd;
      check("req_rdy_before_accept", 32'(req_rdy), 32'd1);
      req_val      = 1'b1;
      req_value    = v.value;
      req_odd_only = v.odd;
      @(posedge clk);
      #1;
      req_val      = 1'b0;
      req_value    = 16'hDEAD;
      req_odd_only = ~v.odd;
      check("done_cleared_on_accept", 32'(done), 32'd0);
      check("busy_after_accept", 32'(busy), 32'd1);
      cyc = 0;
      while (!done && cyc < 20000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("done_within_budget", 32'(done), 32'd1);
      if (exp_q.size() == 0) begin
         check("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         $display("value=%0d odd=%0d -> is_prime=%0d factor=%0d txns=%0d cycles=%0d",
                  e.value, e.odd, is_prime, factor, txn, cyc);
         check("is_prime", 32'(is_prime), 32'(e.exp_prime));
         check("factor", 32'(factor), 32'(e.exp_factor));
         check("txn_count", txn, e.exp_txn);
         check("divisor_sequence_errors", seq_err, 32'd0);
         check("operand_stability_errors", stab_err, 32'd0);
         check("busy_in_done", 32'(busy), 32'd0);
         if (e.exp_txn == 0) check("zero_txn_latency", cyc, 32'd1);
`ifdef PRIME_CTRL_CYCLE_COUNT_EN
         check("cycles_count", cycles, cyc);
`endif
      end
   endtask

   initial begin : main
      vec_t        nine;
      int unsigned cyc;
      logic [15:0] held_factor;
      logic        held_prime;

      //             value   odd stall resp prime factor txn
      vecs[0]  = '{16'd0,     1'b0, 0, 0, 1'b0, 16'd0, 0};
      vecs[1]  = '{16'd1,     1'b0, 0, 0, 1'b0, 16'd0, 0};
      vecs[2]  = '{16'd2,     1'b0, 0, 0, 1'b1, 16'd0, 0};
      vecs[3]  = '{16'd3,     1'b1, 0, 0, 1'b1, 16'd0, 0};
      vecs[4]  = '{16'd4,     1'b0, 0, 0, 1'b0, 16'd2, 1};
      vecs[5]  = '{16'd97,    1'b1, 0, 0, 1'b1, 16'd0, 5};
      vecs[6]  = '{16'd97,    1'b0, 0, 0, 1'b1, 16'd0, 8};
      vecs[7]  = '{16'd91,    1'b1, 0, 3, 1'b0, 16'd7, 4};
      vecs[8]  = '{16'd65535, 1'b0, 0, 0, 1'b0, 16'd3, 2};
      vecs[9]  = '{16'd25,    1'b1, 2, 1, 1'b0, 16'd5, 3};
      vecs[10] = '{16'd65521, 1'b1, 5, 0, 1'b1, 16'd0, 128};
      vecs[11] = '{16'd9,     1'b0, 0, 0, 1'b0, 16'd3, 2};
      nine = vecs[11];

      reset        = 1'b1;
      req_val      = 1'b0;
      req_value    = '0;
      req_odd_only = 1'b0;
      stall        = 0;
      resp_delay   = 0;
      txn          = 0;
      seq_err      = 0;
      stab_err     = 0;
      exp_div      = 16'd2;
      cur_value    = '0;
      cur_odd      = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_req_rdy", 32'(req_rdy), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_is_prime", 32'(is_prime), 32'd0);
      check("reset_factor", 32'(factor), 32'd0);
      check("reset_istream_val", 32'(div_istream_val), 32'd0);
      check("reset_ostream_rdy", 32'(div_ostream_rdy), 32'd0);
      check("reset_divisor", 32'(div_divisor), 32'd0);
      check("reset_dividend", 32'(div_dividend), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Back-to-back: each request after the first is accepted from DONE.
      for (int i = 0; i < 11; i++) run_vec(vecs[i]);

      // Result held in DONE while no request arrives.
      held_factor = factor;
      held_prime  = is_prime;
      repeat (4) @(posedge clk);
      #1;
      check("done_held", 32'(done), 32'd1);
      check("is_prime_held", 32'(is_prime), 32'(held_prime));
      check("factor_held", 32'(factor), 32'(held_factor));
      check("req_rdy_in_done", 32'(req_rdy), 32'd1);

      // Reset while waiting in DIV_RESP with the divider result outstanding.
      @(negedge clk);
      stall      = 0;
      resp_delay = 1000;
      txn        = 0;
      exp_div    = 16'd2;
      cur_value  = 16'd65521;
      cur_odd    = 1'b1;
      req_val      = 1'b1;
      req_value    = 16'd65521;
      req_odd_only = 1'b1;
      @(posedge clk);
      #1;
      req_val = 1'b0;
      cyc = 0;
      while (!div_ostream_rdy && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("reached_div_resp", 32'(div_ostream_rdy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("midreset_req_rdy", 32'(req_rdy), 32'd1);
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_done", 32'(done), 32'd0);
      check("midreset_ostream_rdy", 32'(div_ostream_rdy), 32'd0);
      check("midreset_istream_val", 32'(div_istream_val), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      run_vec(nine);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
